result_mem_reader: RTL and testbench
====================================

RESULT_MEM_READER -- requirements
Module: result_mem_reader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, the result word width.
REQ-002 The block SHALL have parameter DEPTH, default 4, the number of entries; it SHALL be a power of two and addresses SHALL be log2(DEPTH) bits.
REQ-003 clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write strobe from the ALU side.
REQ-006 wr_addr  input  2  write entry index.
REQ-007 wr_data  input  DATA_W  ALU result to store.
REQ-008 wr_err  input  1  ALU carry/error flag to store with the result.
REQ-009 clr_all  input  1  clears all entry-valid bits.
REQ-010 rd_req  input  1  read request.
REQ-011 rd_addr  input  2  start entry index of the read.
REQ-012 rd_burst  input  1  0 = single beat, 1 = DEPTH beats.
REQ-013 rd_req_ready  output  1  request accepted this cycle when high with rd_req.
REQ-014 rd_valid  output  1  read beat present.
REQ-015 rd_ready  input  1  consumer accepts the beat.
REQ-016 rd_data  output  DATA_W  beat data.
REQ-017 rd_err  output  1  stored error flag for the beat.
REQ-018 rd_empty  output  1  beat's entry was never written since the last reset or clear.
REQ-019 rd_last  output  1  final beat of the request.
REQ-020 rd_done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-021 Storage SHALL be DEPTH entries of {err, data, valid}; on a clock edge with wr_en=1, entry wr_addr SHALL take {wr_err, wr_data} and valid=1.
REQ-022 Writes SHALL be accepted in every cycle and FSM state; no write back-pressure exists.
REQ-023 On clr_all=1, all valid bits SHALL clear; if wr_en=1 in the same cycle, the written entry SHALL end valid=1.
REQ-024 The FSM SHALL have states IDLE, FETCH, PRESENT; rd_req_ready SHALL be 1 only in IDLE.
REQ-025 IDLE: on rd_req=1, it SHALL capture rd_addr and a beat count (1 or DEPTH), then go to FETCH.
REQ-026 FETCH, one cycle: it SHALL register the entry at the current address into rd_data/rd_err/rd_empty (rd_empty = not valid), set rd_valid, then go to PRESENT.
REQ-027 A write to the fetched entry in the FETCH cycle SHALL be visible in the fetched beat (write-first).
REQ-028 Empty entries SHALL return rd_data=0, rd_err=0, rd_empty=1.
REQ-029 PRESENT: outputs SHALL hold stable until rd_ready=1; later writes SHALL NOT alter a presented beat.
REQ-030 On acceptance in PRESENT with beats remaining: the address SHALL increment modulo DEPTH, rd_valid SHALL drop, and the FSM SHALL go to FETCH.
REQ-031 On acceptance of the final beat: rd_valid SHALL drop, rd_done SHALL pulse in the next cycle, and the FSM SHALL return to IDLE.
REQ-032 Consequence of REQ-030: burst beats SHALL be a minimum of 2 cycles apart, and first-beat latency SHALL be 2 cycles after acceptance.
REQ-033 rd_last SHALL be 1 with rd_valid on the final beat only.
REQ-034 rd_req outside IDLE SHALL be ignored and not queued.
REQ-035 rd_ready while rd_valid=0 SHALL be ignored.

Reset
REQ-036 With rst_n=0, asynchronously: the FSM SHALL be in IDLE; rd_valid, rd_last, rd_done, rd_data, rd_err SHALL be 0; rd_empty SHALL be 0; all valid bits SHALL be 0; the beat counter and address SHALL be 0.
REQ-037 Reset mid-burst SHALL abort the burst with no rd_done pulse.
REQ-038 Stored data/err need not reset; only valid bits SHALL reset.

Structure
REQ-039 A shared package SHALL hold the FSM state enum, DATA_W/DEPTH defaults and the entry record type {err, data, valid}.
REQ-040 One sub-module SHALL exist: result_mem_store (storage, write port, clear, combinational read port).

Verification
REQ-041 Reset, then single read of addr 2 -> rd_valid 2 cycles after acceptance, rd_empty=1, rd_data=0, rd_last=1, rd_done pulse after accept.
REQ-042 Write {err=1, data=4'h9} to addr 3, single read of addr 3 -> rd_data=9, rd_err=1, rd_empty=0.
REQ-043 Write entries 0..3 = 1,2,3,4; burst from addr 2 -> beats 3,4,1,2; rd_last only on the 4th beat.
REQ-044 Hold rd_ready=0 for 5 cycles in PRESENT while writing the presented entry -> outputs unchanged; rd_req is ignored (rd_req_ready=0).
REQ-045 clr_all and wr_en to addr 1 in the same cycle, then burst from 0 -> only beat 2 (addr 1) has rd_empty=0.
REQ-046 Assert rst_n=0 during the beat-2 PRESENT state of a burst -> immediate IDLE, rd_valid=0, no rd_done; a subsequent read returns rd_empty=1.

Source files
------------

// File: rtl/result_mem_reader_pkg.sv
// Shared definitions for the result memory reader.
// Holds the reader FSM state encoding, default geometry and the stored
// entry record layout. Other files in this block import it.
package result_mem_reader_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  // One stored result at the default width: error flag, data, written flag.
  typedef struct packed {
    logic                  err;
    logic [DATA_W_DEF-1:0] data;
    logic                  valid;
  } entry_t;

endpackage

// File: rtl/result_mem_store.sv
// Result storage: DEPTH entries of {err, data, valid}.
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset (valid bits only)
//   i_wr_en/addr/data/err    write port, accepted every cycle
//   i_clr_all                clears every valid bit
//   i_rd_addr                combinational read address
//   o_rd_data/err/empty      read port; empty entries read as data=0, err=0
module result_mem_store
  import result_mem_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_err,
  input  logic              i_clr_all,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_err,
  output logic              o_rd_empty
);

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_err;
  logic [DEPTH-1:0]  r_valid;

  logic              w_hit;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_err;

  // Payload is never reset; only the valid bits carry meaning after reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_data[i_wr_addr] <= i_wr_data;
      r_err[i_wr_addr]  <= i_wr_err;
    end
  end

  // A write in the same cycle as a clear wins for its own entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else begin
      if (i_clr_all) r_valid <= '0;
      if (i_wr_en)   r_valid[i_wr_addr] <= 1'b1;
    end
  end

  // Write-first bypass so a beat fetched in the write cycle sees the new value.
  assign w_hit   = i_wr_en && (i_wr_addr == i_rd_addr);
  assign w_valid = w_hit || r_valid[i_rd_addr];
  assign w_data  = w_hit ? i_wr_data : r_data[i_rd_addr];
  assign w_err   = w_hit ? i_wr_err  : r_err[i_rd_addr];

  assign o_rd_data  = w_valid ? w_data : '0;
  assign o_rd_err   = w_valid ? w_err  : 1'b0;
  assign o_rd_empty = !w_valid;

endmodule

// File: rtl/result_mem_reader.sv
// Result memory with a single/burst read port.
// The ALU side writes {err, data} into entries at any time; a reader asks
// for one entry or a DEPTH-beat wrapping burst and gets registered beats on a
// valid/ready handshake, with rd_last on the final beat and rd_done one cycle
// after the final beat is taken.
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_wr_en/addr/data/err, i_clr_all  write side
//   i_rd_req/addr/burst, o_rd_req_ready  read request handshake
//   o_rd_valid, i_rd_ready            beat handshake
//   o_rd_data/err/empty/last          beat contents
//   o_rd_done                         pulse after final beat accepted
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | waiting for a read request; only state taking rd_req
// ST_FETCH   | one cycle: register the entry at r_addr as a beat
// ST_PRESENT | beat on the outputs, held until rd_ready
module result_mem_reader
  import result_mem_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_err,
  input  logic              i_clr_all,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_burst,
  output logic              o_rd_req_ready,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_err,
  output logic              o_rd_empty,
  output logic              o_rd_last,
  output logic              o_rd_done
);

  localparam int CNT_W = ADDR_W + 1;

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
  logic              r_rd_valid, w_rd_valid_nxt;
  logic [DATA_W-1:0] r_rd_data,  w_rd_data_nxt;
  logic              r_rd_err,   w_rd_err_nxt;
  logic              r_rd_empty, w_rd_empty_nxt;
  logic              r_rd_last,  w_rd_last_nxt;
  logic              r_rd_done,  w_rd_done_nxt;

  logic [DATA_W-1:0] w_st_data;
  logic              w_st_err;
  logic              w_st_empty;

  result_mem_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_store (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .i_wr_err   (i_wr_err),
    .i_clr_all  (i_clr_all),
    .i_rd_addr  (r_addr),
    .o_rd_data  (w_st_data),
    .o_rd_err   (w_st_err),
    .o_rd_empty (w_st_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_err   <= 1'b0;
      r_rd_empty <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_err   <= w_rd_err_nxt;
      r_rd_empty <= w_rd_empty_nxt;
      r_rd_last  <= w_rd_last_nxt;
      r_rd_done  <= w_rd_done_nxt;
    end
  end

  // r_cnt holds the beats still to deliver, including the one in flight.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_cnt_nxt      = r_cnt;
    w_rd_valid_nxt = r_rd_valid;
    w_rd_data_nxt  = r_rd_data;
    w_rd_err_nxt   = r_rd_err;
    w_rd_empty_nxt = r_rd_empty;
    w_rd_last_nxt  = r_rd_last;
    w_rd_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_rd_req) begin
          w_addr_nxt  = i_rd_addr;
          w_cnt_nxt   = i_rd_burst ? CNT_W'(DEPTH) : CNT_W'(1);
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_rd_valid_nxt = 1'b1;
        w_rd_data_nxt  = w_st_data;
        w_rd_err_nxt   = w_st_err;
        w_rd_empty_nxt = w_st_empty;
        w_rd_last_nxt  = (r_cnt == CNT_W'(1));
        w_state_nxt    = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (i_rd_ready) begin
          w_rd_valid_nxt = 1'b0;
          w_rd_last_nxt  = 1'b0;
          if (r_cnt == CNT_W'(1)) begin
            w_rd_done_nxt = 1'b1;
            w_state_nxt   = ST_IDLE;
          end else begin
            // DEPTH is a power of two, so the natural wrap is modulo DEPTH.
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_cnt_nxt   = r_cnt - CNT_W'(1);
            w_state_nxt = ST_FETCH;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_rd_req_ready = (r_state == ST_IDLE);
  assign o_rd_valid     = r_rd_valid;
  assign o_rd_data      = r_rd_data;
  assign o_rd_err       = r_rd_err;
  assign o_rd_empty     = r_rd_empty;
  assign o_rd_last      = r_rd_last;
  assign o_rd_done      = r_rd_done;

endmodule

// File: tb/tb_result_mem_reader.sv
module tb_result_mem_reader;

  localparam int DW = 4;
  localparam int DP = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_err = 1'b0;
  logic          clr_all = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_burst = 1'b0;
  logic          rd_ready = 1'b0;
  logic          o_rd_req_ready;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_err;
  logic          o_rd_empty;
  logic          o_rd_last;
  logic          o_rd_done;

  int errors = 0;
  int checks = 0;

  result_mem_reader #(.DATA_W(DW), .DEPTH(DP)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_wr_en        (wr_en),
    .i_wr_addr      (wr_addr),
    .i_wr_data      (wr_data),
    .i_wr_err       (wr_err),
    .i_clr_all      (clr_all),
    .i_rd_req       (rd_req),
    .i_rd_addr      (rd_addr),
    .i_rd_burst     (rd_burst),
    .o_rd_req_ready (o_rd_req_ready),
    .o_rd_valid     (o_rd_valid),
    .i_rd_ready     (rd_ready),
    .o_rd_data      (o_rd_data),
    .o_rd_err       (o_rd_err),
    .o_rd_empty     (o_rd_empty),
    .o_rd_last      (o_rd_last),
    .o_rd_done      (o_rd_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: the memory as plain arrays plus a description of
  // the read transaction in progress (next beat address, beats left, whether
  // a beat is showing and what it holds).
  logic [DW-1:0] mm_data [DP];
  bit            mm_err  [DP];
  bit            mm_val  [DP];
  bit            busy = 0;      // a request is in progress
  bit            showing = 0;   // a beat is on the outputs
  int            next_addr = 0;
  int            beats_left = 0;
  bit            m_done = 0;
  int            b_data = 0;
  bit            b_err = 0;
  bit            b_empty = 0;
  bit            b_last = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0; showing = 0; next_addr = 0; beats_left = 0; m_done = 0;
      b_data = 0; b_err = 0; b_empty = 0; b_last = 0;
      for (int i = 0; i < DP; i++) mm_val[i] = 0;
    end else begin
      m_done = 0;
      if (!busy) begin
        if (rd_req) begin
          busy = 1;
          next_addr = int'(rd_addr);
          beats_left = rd_burst ? DP : 1;
        end
      end else if (showing) begin
        if (rd_ready) begin
          showing = 0;
          b_last = 0;
          beats_left--;
          if (beats_left == 0) begin
            busy = 0;
            m_done = 1;
          end else begin
            next_addr = (next_addr + 1) % DP;
          end
        end
      end else begin
        // The beat reflects the entry as it stands, with a same-cycle write
        // to it taking priority.
        if (wr_en && int'(wr_addr) == next_addr) begin
          b_empty = 0; b_data = int'(wr_data); b_err = wr_err;
        end else if (mm_val[next_addr]) begin
          b_empty = 0; b_data = int'(mm_data[next_addr]); b_err = mm_err[next_addr];
        end else begin
          b_empty = 1; b_data = 0; b_err = 0;
        end
        b_last = (beats_left == 1);
        showing = 1;
      end
      if (clr_all) for (int i = 0; i < DP; i++) mm_val[i] = 0;
      if (wr_en) begin
        mm_data[wr_addr] = wr_data;
        mm_err[wr_addr]  = wr_err;
        mm_val[wr_addr]  = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("req_ready", int'(o_rd_req_ready), int'(!busy));
    chk("valid", int'(o_rd_valid), int'(showing));
    chk("done", int'(o_rd_done), int'(m_done));
    chk("last", int'(o_rd_last), int'(b_last && showing));
    if (showing) begin
      chk("data", int'(o_rd_data), b_data);
      chk("err", int'(o_rd_err), int'(b_err));
      chk("empty", int'(o_rd_empty), int'(b_empty));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int a, input int d, input bit e);
    wr_en = 1; wr_addr = AW'(a); wr_data = DW'(d); wr_err = e;
    tick();
    wr_en = 0;
  endtask

  task automatic start_read(input int a, input bit b);
    rd_req = 1; rd_addr = AW'(a); rd_burst = b;
    tick();
    rd_req = 0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!o_rd_valid && n < 20) begin
      tick();
      n++;
    end
    chk("beat_timeout", int'(o_rd_valid), 1);
  endtask

  task automatic get_beat(output int d, output bit e, output bit emp, output bit lst);
    wait_valid();
    d = int'(o_rd_data); e = o_rd_err; emp = o_rd_empty; lst = o_rd_last;
    rd_ready = 1;
    tick();
    rd_ready = 0;
  endtask

  int d;
  bit e, emp, lst;

  initial begin
    repeat (3) tick();
    chk("rst_valid", int'(o_rd_valid), 0);
    chk("rst_ready", int'(o_rd_req_ready), 1);
    chk("rst_empty", int'(o_rd_empty), 0);
    chk("rst_data", int'(o_rd_data), 0);
    rst_n = 1;
    tick();

    // Single read of an unwritten entry: beat two cycles after acceptance.
    start_read(2, 0);
    chk("lat_fetch_valid", int'(o_rd_valid), 0);
    tick();
    chk("lat_beat_valid", int'(o_rd_valid), 1);
    chk("t1_empty", int'(o_rd_empty), 1);
    chk("t1_data", int'(o_rd_data), 0);
    chk("t1_err", int'(o_rd_err), 0);
    chk("t1_last", int'(o_rd_last), 1);
    rd_ready = 1;
    tick();
    rd_ready = 0;
    chk("t1_done", int'(o_rd_done), 1);
    chk("t1_valid_drop", int'(o_rd_valid), 0);
    tick();
    chk("t1_done_pulse", int'(o_rd_done), 0);

    // Stored data and error flag.
    write(3, 9, 1);
    start_read(3, 0);
    get_beat(d, e, emp, lst);
    chk("t2_data", d, 9);
    chk("t2_err", int'(e), 1);
    chk("t2_empty", int'(emp), 0);

    // Wrapping burst from entry 2.
    for (int i = 0; i < DP; i++) write(i, i + 1, 0);
    start_read(2, 1);
    for (int i = 0; i < DP; i++) begin
      get_beat(d, e, emp, lst);
      chk("t3_data", d, ((2 + i) % DP) + 1);
      chk("t3_last", int'(lst), int'(i == DP - 1));
    end

    // Back-pressure: beat holds while its entry is rewritten; rd_req ignored.
    start_read(0, 0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_addr = 0; wr_data = 4'hF; wr_err = 1; rd_req = 1;
      tick();
      chk("t4_hold_data", int'(o_rd_data), 1);
      chk("t4_hold_err", int'(o_rd_err), 0);
      chk("t4_hold_valid", int'(o_rd_valid), 1);
      chk("t4_req_ready", int'(o_rd_req_ready), 0);
    end
    wr_en = 0; rd_req = 0; rd_ready = 1;
    tick();
    rd_ready = 0;
    repeat (3) tick();
    chk("t4_not_queued", int'(o_rd_valid), 0);

    // Clear with a simultaneous write to entry 1.
    clr_all = 1; wr_en = 1; wr_addr = 1; wr_data = 5; wr_err = 0;
    tick();
    clr_all = 0; wr_en = 0;
    start_read(0, 1);
    for (int i = 0; i < DP; i++) begin
      get_beat(d, e, emp, lst);
      chk("t5_empty", int'(emp), int'(i != 1));
      if (i == 1) chk("t5_data", d, 5);
    end

    // Reset during the second beat of a burst.
    for (int i = 0; i < DP; i++) write(i, 7, 0);
    start_read(0, 1);
    get_beat(d, e, emp, lst);
    wait_valid();
    rst_n = 0;
    #1;
    chk("t6_valid", int'(o_rd_valid), 0);
    chk("t6_ready", int'(o_rd_req_ready), 1);
    chk("t6_done", int'(o_rd_done), 0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_done", int'(o_rd_done), 0);
    end
    start_read(1, 0);
    get_beat(d, e, emp, lst);
    chk("t6_empty_after", int'(emp), 1);

    // Randomised traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      wr_en    = ($urandom % 2) == 0;
      wr_addr  = AW'($urandom);
      wr_data  = DW'($urandom);
      wr_err   = $urandom % 2;
      clr_all  = ($urandom % 16) == 0;
      rd_req   = ($urandom % 3) == 0;
      rd_addr  = AW'($urandom);
      rd_burst = $urandom % 2;
      rd_ready = ($urandom % 3) != 0;
      if (c % 500 == 250) begin
        rst_n = 0;
        #2;
        rst_n = 1;
      end
      @(posedge clk);
      #1;
    end
    wr_en = 0; clr_all = 0; rd_req = 0; rd_ready = 1;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
